// File: rtl/fb_port_arbiter_if.sv
// Port bundle between the frame-buffer arbiter, its clients (scan-out, capture,
// clear control) and the single-port BRAM primitive.
interface fb_port_arbiter_if #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              RD_EN;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              CLR_START;
  logic [DATA_W-1:0] CLR_VALUE;
  logic              CLR_BUSY;
  logic [LVL_W-1:0]  FIFO_LEVEL;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_DIN;
  logic [DATA_W-1:0] MEM_DOUT;

  modport slave (
    input  RD_EN, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, CLR_START, CLR_VALUE, MEM_DOUT,
    output RD_DATA, RD_VALID, WR_READY, CLR_BUSY, FIFO_LEVEL, MEM_ADDR, MEM_WE, MEM_DIN
  );

  modport master (
    output RD_EN, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, CLR_START, CLR_VALUE, MEM_DOUT,
    input  RD_DATA, RD_VALID, WR_READY, CLR_BUSY, FIFO_LEVEL, MEM_ADDR, MEM_WE, MEM_DIN
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads always win, capture writes
// queue in a small FIFO and drain on idle cycles, full-buffer clear sequencer.
module fb_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int MEM_WORDS  = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  fb_port_arbiter_if.slave    bus
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                LVL_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t            state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_nxt;

  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              rd_valid_q;

  logic              fifo_empty;
  logic              push, pop, clr_wr, clr_accept;

  assign fifo_empty = (level == '0);

  assign bus.WR_READY = !RESET && (state == S_IDLE) && (level != FULL_LVL);
  assign push         = bus.WR_VALID && bus.WR_READY;

  // The reader owns the port whenever it asks; clear and drain only use leftovers.
  assign clr_wr     = !RESET && !bus.RD_EN && (state == S_CLEAR);
  assign pop        = !RESET && !bus.RD_EN && (state != S_CLEAR) && !fifo_empty;
  assign clr_accept = bus.CLR_START && (state == S_IDLE);

  assign level_nxt = level + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.CLR_START) state_nxt = (!fifo_empty || push) ? S_DRAIN : S_CLEAR;
      S_DRAIN: if (level_nxt == '0) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_wr && (clr_cnt == LAST_ADDR)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.MEM_ADDR = bus.RD_ADDR;
    bus.MEM_DIN  = fifo_data[rd_ptr];
    bus.MEM_WE   = 1'b0;
    if (bus.RD_EN) begin
      bus.MEM_ADDR = bus.RD_ADDR;
    end else if (clr_wr) begin
      bus.MEM_ADDR = clr_cnt;
      bus.MEM_DIN  = clr_val;
      bus.MEM_WE   = 1'b1;
    end else if (pop) begin
      bus.MEM_ADDR = fifo_addr[rd_ptr];
      bus.MEM_WE   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      clr_cnt    <= '0;
      clr_val    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level      <= level_nxt;
      rd_valid_q <= bus.RD_EN;
      if (clr_accept) begin
        clr_val <= bus.CLR_VALUE;
        clr_cnt <= '0;
      end else if (clr_wr && (clr_cnt != LAST_ADDR)) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.WR_ADDR;
      fifo_data[wr_ptr] <= bus.WR_DATA;
    end
  end

  assign bus.RD_DATA    = bus.MEM_DOUT;
  assign bus.RD_VALID   = rd_valid_q;
  assign bus.CLR_BUSY   = (state != S_IDLE);
  assign bus.FIFO_LEVEL = level;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: BRAM model, write/read scoreboards
// fed at stimulus time, directed scenarios for priority, backpressure and clear.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int WORDS  = 64;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_clr;
  } wr_exp_t;

  logic CLK = 1'b0;
  logic RESET;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(WORDS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [DATA_W-1:0] bram    [2**ADDR_W];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];

  always @(posedge CLK) begin
    if (bus.MEM_WE) bram[bus.MEM_ADDR] <= bus.MEM_DIN;
    bus.MEM_DOUT <= bram[bus.MEM_ADDR];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Scoreboard state
  wr_exp_t           wr_q [$];
  logic [DATA_W-1:0] rd_q [$];
  int                exp_level = 0;
  logic              exp_busy  = 1'b0;
  logic              prev_rd_en = 1'b0;

  always @(negedge CLK) begin
    wr_exp_t           w;
    logic [DATA_W-1:0] e;
    if (RESET) begin
      check("rst_mem_we", bus.MEM_WE, 0);
      check("rst_wr_ready", bus.WR_READY, 0);
      wr_q.delete();
      rd_q.delete();
      exp_level  = 0;
      exp_busy   = 1'b0;
      prev_rd_en = 1'b0;
    end else begin
      check("rd_valid", bus.RD_VALID, prev_rd_en);
      if (bus.RD_VALID) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("rd_data", bus.RD_DATA, e);
        end
      end
      check("clr_busy", bus.CLR_BUSY, exp_busy);
      check("fifo_level", bus.FIFO_LEVEL, exp_level);
      check("wr_ready", bus.WR_READY, (!exp_busy && exp_level < DEPTH));
      if (bus.MEM_WE) begin
        check("we_during_rd", bus.RD_EN, 0);
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", bus.MEM_ADDR, w.addr);
          check("wr_data", bus.MEM_DIN, w.data);
          ref_mem[w.addr] = w.data;
          if (!w.is_clr) exp_level--;
          else if (w.addr == ADDR_W'(WORDS - 1)) exp_busy = 1'b0;
        end
      end
      if (bus.RD_EN) rd_q.push_back(ref_mem[bus.RD_ADDR]);
      prev_rd_en = bus.RD_EN;
      if (bus.WR_VALID && bus.WR_READY) begin
        wr_q.push_back('{bus.WR_ADDR, bus.WR_DATA, 1'b0});
        exp_level++;
      end
      if (bus.CLR_START && !exp_busy) begin
        for (int i = 0; i < WORDS; i++) wr_q.push_back('{ADDR_W'(i), bus.CLR_VALUE, 1'b1});
        exp_busy = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_clear_done(input string tag);
    int n;
    n = 0;
    while (bus.CLR_BUSY !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, busy_cnt, rd_cnt, n;

    for (int i = 0; i < 2**ADDR_W; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end
    RESET         = 1'b1;
    bus.RD_EN     = 1'b0;
    bus.RD_ADDR   = '0;
    bus.WR_VALID  = 1'b1;
    bus.WR_ADDR   = 14'h0005;
    bus.WR_DATA   = 8'h11;
    bus.CLR_START = 1'b1;
    bus.CLR_VALUE = 8'hEE;

    // Reset with write and clear requests active
    repeat (3) tick();
    RESET         = 1'b0;
    bus.WR_VALID  = 1'b0;
    bus.CLR_START = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", bus.CLR_BUSY, 0);
    check("post_rst_level", bus.FIFO_LEVEL, 0);
    check("post_rst_ready", bus.WR_READY, 1);

    // Read priority over a queued write
    tick();
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR  = 14'h0010;
    bus.WR_DATA  = 8'hAB;
    tick();
    bus.WR_VALID = 1'b0;
    bus.RD_EN    = 1'b1;
    bus.RD_ADDR  = 14'h0020;
    repeat (5) begin
      @(negedge CLK);
      check("prio_we_low", bus.MEM_WE, 0);
      tick();
    end
    bus.RD_EN = 1'b0;
    @(negedge CLK);
    check("prio_we", bus.MEM_WE, 1);
    check("prio_addr", bus.MEM_ADDR, 14'h0010);
    check("prio_data", bus.MEM_DIN, 8'hAB);
    tick();

    // Backpressure with reader hogging the port
    bus.RD_EN = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_ADDR  = ADDR_W'(8'h30 + i);
      bus.WR_DATA  = DATA_W'(8'hC0 + i);
      @(negedge CLK);
      if (bus.WR_READY) acc++;
      tick();
    end
    bus.WR_VALID = 1'b0;
    @(negedge CLK);
    check("bp_accepted", acc, 4);
    check("bp_ready_full", bus.WR_READY, 0);
    check("bp_level_full", bus.FIFO_LEVEL, 4);
    tick();
    bus.RD_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_drain_we", bus.MEM_WE, 1);
      check("bp_drain_addr", bus.MEM_ADDR, 8'h30 + i);
      tick();
    end
    @(negedge CLK);
    check("bp_ready_after", bus.WR_READY, 1);
    tick();

    // Clear with a read every third cycle
    bus.CLR_START = 1'b1;
    bus.CLR_VALUE = 8'h5A;
    tick();
    bus.CLR_START = 1'b0;
    bus.CLR_VALUE = 8'h99;
    busy_cnt = 0;
    rd_cnt   = 0;
    n        = 0;
    while (n < 400) begin
      bus.RD_EN   = (n % 3 == 2);
      bus.RD_ADDR = ADDR_W'($urandom_range(WORDS - 1));
      @(negedge CLK);
      if (!bus.CLR_BUSY) break;
      busy_cnt++;
      if (bus.RD_EN) rd_cnt++;
      tick();
      n++;
    end
    if (n >= 400) check("clr_timeout", 1, 0);
    check("clr_duration", busy_cnt, WORDS + rd_cnt);
    tick();
    for (int i = 0; i <= WORDS; i++) begin
      bus.RD_EN   = (i < WORDS);
      bus.RD_ADDR = ADDR_W'(i);
      @(negedge CLK);
      if (i > 0) check("clr_readback", bus.RD_DATA, 8'h5A);
      tick();
    end
    bus.RD_EN = 1'b0;
    tick();

    // Clear requested while the FIFO holds writes
    bus.RD_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_ADDR  = ADDR_W'(i);
      bus.WR_DATA  = 8'hFF;
      tick();
    end
    bus.WR_VALID  = 1'b0;
    bus.CLR_START = 1'b1;
    bus.CLR_VALUE = 8'h00;
    tick();
    bus.CLR_START = 1'b0;
    bus.RD_EN     = 1'b0;
    @(negedge CLK);
    check("drain_first_addr", bus.MEM_ADDR, 0);
    check("drain_first_data", bus.MEM_DIN, 8'hFF);
    tick();
    wait_clear_done("drain_clear");
    for (int i = 0; i <= 3; i++) begin
      bus.RD_EN   = (i < 3);
      bus.RD_ADDR = ADDR_W'(i);
      @(negedge CLK);
      if (i > 0) check("drain_readback", bus.RD_DATA, 8'h00);
      tick();
    end
    bus.RD_EN = 1'b0;
    tick();

    // Reset in the middle of a clear
    bus.CLR_START = 1'b1;
    bus.CLR_VALUE = 8'h33;
    tick();
    bus.CLR_START = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge CLK);
      if (bus.MEM_WE && bus.MEM_ADDR == 14'd19) break;
      tick();
      n++;
    end
    if (n >= 200) check("midclr_timeout", 1, 0);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("midclr_busy", bus.CLR_BUSY, 0);
    check("midclr_we", bus.MEM_WE, 0);
    check("midclr_partial_lo", ref_mem[19], 8'h33);
    check("midclr_partial_hi", ref_mem[20], 8'h00);
    tick();
    bus.CLR_START = 1'b1;
    bus.CLR_VALUE = 8'h77;
    tick();
    bus.CLR_START = 1'b0;
    @(negedge CLK);
    check("restart_we", bus.MEM_WE, 1);
    check("restart_addr", bus.MEM_ADDR, 0);
    tick();
    wait_clear_done("restart_clear");
    bus.RD_EN   = 1'b1;
    bus.RD_ADDR = 14'd25;
    tick();
    bus.RD_EN = 1'b0;
    @(negedge CLK);
    check("restart_readback", bus.RD_DATA, 8'h77);
    tick();
    tick();
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
